// File: rtl/spi_mem_target.sv
// -----------------------------------------------------------------------------
// spi_mem_target
//   SPI mode-0 responder that bridges an SPI master's memory protocol onto a
//   simple synchronous single-port RAM. Frame: CS low, 8-bit command
//   (0x03 read / 0x02 write), 16-bit address MSB first, then a stream of data
//   bytes with 16-bit wrapping address auto-increment. SCLK/CS/MOSI are
//   oversampled in clk_i (clk_i >= 8x SCLK).
//
// Ports
//   clk_i, rst_n_i       target clock, async active-low reset
//   spi_sclk_i           SPI clock (CPOL=0, CPHA=0)
//   spi_cs_i             chip select, active low
//   spi_mosi_i           master-out data, MSB first
//   spi_miso_o           target-out data, MSB first
//   spi_miso_oe_o        MISO enable, high only in the read data phase
//   mem_addr_o           RAM address
//   mem_rd_o             one-cycle read strobe; data returns 1 clk_i later
//   mem_rdata_i          RAM read data
//   mem_wr_o             one-cycle write strobe
//   mem_wdata_o          RAM write data, valid with mem_wr_o
//   busy_o               high while a frame is in progress
//   cmd_err_o            one-cycle pulse on an unrecognised command byte
// -----------------------------------------------------------------------------
module spi_mem_target (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        spi_sclk_i,
    input  logic        spi_cs_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    output logic        spi_miso_oe_o,
    output logic [15:0] mem_addr_o,
    output logic        mem_rd_o,
    input  logic [7:0]  mem_rdata_i,
    output logic        mem_wr_o,
    output logic [7:0]  mem_wdata_o,
    output logic        busy_o,
    output logic        cmd_err_o
);

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD_FETCH,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_IGNORE
    } state_t;

    // ---------------------------------------------------------------- sync
    logic [1:0] r_sclk_sync;
    logic       r_sclk_prev;
    logic [1:0] r_cs_sync;
    logic       r_cs_prev;
    logic [1:0] r_mosi_sync;

    // NOTE: the CS synchroniser resets to "selected" (0) so that a frame already
    // in flight when reset releases never produces a falling edge; the target
    // only wakes on the next genuine CS fall.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sclk_sync <= 2'b00;
            r_sclk_prev <= 1'b0;
            r_cs_sync   <= 2'b00;
            r_cs_prev   <= 1'b0;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], spi_sclk_i};
            r_sclk_prev <= r_sclk_sync[1];
            r_cs_sync   <= {r_cs_sync[0], spi_cs_i};
            r_cs_prev   <= r_cs_sync[1];
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi_i};
        end
    end

    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_cs_fall;
    logic        w_cs_rise;
    logic [15:0] w_rx_shift;

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_prev;
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_prev;
    assign w_cs_fall   = ~r_cs_sync[1] & r_cs_prev;
    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_prev;

    // ------------------------------------------------------------- datapath
    state_t      r_state,     w_state_nxt;
    logic [3:0]  r_bit_cnt,   w_bit_cnt_nxt;
    logic [15:0] r_rx,        w_rx_nxt;
    logic        r_is_read,   w_is_read_nxt;
    logic [7:0]  r_tx,        w_tx_nxt;
    logic        r_oe,        w_oe_nxt;
    logic [15:0] r_addr,      w_addr_nxt;
    logic        r_rd,        w_rd_nxt;
    logic        r_wr,        w_wr_nxt;
    logic [7:0]  r_wdata,     w_wdata_nxt;
    logic        r_cmd_err,   w_cmd_err_nxt;

    // MOSI is delayed by the same two flops as SCLK, so the synchronised MOSI
    // lines up with the detected rising edge.
    assign w_rx_shift = {r_rx[14:0], r_mosi_sync[1]};

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 4'd0;
            r_rx      <= 16'h0000;
            r_is_read <= 1'b0;
            r_tx      <= 8'h00;
            r_oe      <= 1'b0;
            r_addr    <= 16'h0000;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_wdata   <= 8'h00;
            r_cmd_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_rx      <= w_rx_nxt;
            r_is_read <= w_is_read_nxt;
            r_tx      <= w_tx_nxt;
            r_oe      <= w_oe_nxt;
            r_addr    <= w_addr_nxt;
            r_rd      <= w_rd_nxt;
            r_wr      <= w_wr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_cmd_err <= w_cmd_err_nxt;
        end
    end

    // NOTE: every signal assigned below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_rx_nxt      = w_sclk_rise ? w_rx_shift : r_rx;
        w_is_read_nxt = r_is_read;
        w_tx_nxt      = r_tx;
        w_oe_nxt      = r_oe;
        // A write strobe is followed by the address increment, so the RAM sees
        // the unincremented address together with mem_wr_o.
        w_addr_nxt    = r_wr ? r_addr + 16'd1 : r_addr;
        w_rd_nxt      = 1'b0;
        w_wr_nxt      = 1'b0;
        w_wdata_nxt   = r_wdata;
        w_cmd_err_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt   = ST_CMD;
                    w_bit_cnt_nxt = 4'd0;
                end
            end
            ST_CMD: begin
                if (w_sclk_rise) begin
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) begin
                        w_bit_cnt_nxt = 4'd0;
                        if (w_rx_shift[7:0] == CMD_READ) begin
                            w_is_read_nxt = 1'b1;
                            w_state_nxt   = ST_ADDR;
                        end else if (w_rx_shift[7:0] == CMD_WRITE) begin
                            w_is_read_nxt = 1'b0;
                            w_state_nxt   = ST_ADDR;
                        end else begin
                            w_state_nxt   = ST_IGNORE;
                            w_cmd_err_nxt = 1'b1;
                        end
                    end
                end
            end
            ST_ADDR: begin
                if (w_sclk_rise) begin
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd15) begin
                        w_bit_cnt_nxt = 4'd0;
                        w_addr_nxt    = w_rx_shift;
                        if (r_is_read) begin
                            w_state_nxt = ST_RD_FETCH;
                            w_rd_nxt    = 1'b1;
                        end else begin
                            w_state_nxt = ST_WR_DATA;
                        end
                    end
                end
            end
            ST_RD_FETCH: begin
                // First cycle here carries the read strobe; the cycle after
                // it sees valid RAM data and loads the transmit register.
                if (!r_rd) begin
                    w_tx_nxt    = mem_rdata_i;
                    w_oe_nxt    = 1'b1;
                    w_state_nxt = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                // The falling edge right after a reload must not shift: the
                // new MSB is already on MISO for the next rising edge.
                if (w_sclk_fall && r_bit_cnt != 4'd0) begin
                    w_tx_nxt = {r_tx[6:0], 1'b0};
                end
                if (w_sclk_rise) begin
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) begin
                        w_bit_cnt_nxt = 4'd0;
                        w_addr_nxt    = r_addr + 16'd1;
                        w_rd_nxt      = 1'b1;
                        w_state_nxt   = ST_RD_FETCH;
                    end
                end
            end
            ST_WR_DATA: begin
                if (w_sclk_rise) begin
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) begin
                        w_bit_cnt_nxt = 4'd0;
                        w_wr_nxt      = 1'b1;
                        w_wdata_nxt   = w_rx_shift[7:0];
                    end
                end
            end
            ST_IGNORE: begin
                w_state_nxt = ST_IGNORE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // CS release ends the frame from any state: partial bytes and pending
        // read data are dropped and MISO is released in the same cycle.
        if (w_cs_rise) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = 4'd0;
            w_oe_nxt      = 1'b0;
            w_tx_nxt      = 8'h00;
            w_rd_nxt      = 1'b0;
            w_wr_nxt      = 1'b0;
            w_cmd_err_nxt = 1'b0;
        end
    end

    assign spi_miso_o    = r_tx[7];
    assign spi_miso_oe_o = r_oe;
    assign mem_addr_o    = r_addr;
    assign mem_rd_o      = r_rd;
    assign mem_wr_o      = r_wr;
    assign mem_wdata_o   = r_wdata;
    assign busy_o        = (r_state != ST_IDLE);
    assign cmd_err_o     = r_cmd_err;

endmodule

// File: tb/tb_spi_mem_target.sv
// -----------------------------------------------------------------------------
// tb_spi_mem_target
//   Drives spi_mem_target as an SPI mode-0 master against a behavioural
//   synchronous RAM. Expected RAM strobes and MISO bytes are queued when the
//   stimulus is issued and compared when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_spi_mem_target;

    localparam int HALF = 8;  // clk_i cycles per SCLK phase

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        spi_sclk_i;
    logic        spi_cs_i;
    logic        spi_mosi_i;
    logic        spi_miso_o;
    logic        spi_miso_oe_o;
    logic [15:0] mem_addr_o;
    logic        mem_rd_o;
    logic [7:0]  mem_rdata_i;
    logic        mem_wr_o;
    logic [7:0]  mem_wdata_o;
    logic        busy_o;
    logic        cmd_err_o;

    spi_mem_target dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .spi_sclk_i    (spi_sclk_i),
        .spi_cs_i      (spi_cs_i),
        .spi_mosi_i    (spi_mosi_i),
        .spi_miso_o    (spi_miso_o),
        .spi_miso_oe_o (spi_miso_oe_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rd_o      (mem_rd_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_wr_o      (mem_wr_o),
        .mem_wdata_o   (mem_wdata_o),
        .busy_o        (busy_o),
        .cmd_err_o     (cmd_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural RAM: read data valid one clk_i after the strobe.
    logic [7:0] ram [0:65535];
    always @(posedge clk_i) begin
        if (mem_rd_o) mem_rdata_i <= ram[mem_addr_o];
        if (mem_wr_o) ram[mem_addr_o] <= mem_wdata_o;
    end

    int n_pass  = 0;
    int n_total = 0;
    int err_count = 0;
    int oe_count  = 0;

    wr_t         wr_q   [$];
    logic [15:0] rd_q   [$];
    logic [7:0]  miso_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard monitor for RAM strobes, sampled away from the active edge.
    wr_t         mon_wr;
    logic [15:0] mon_rd;
    always @(negedge clk_i) begin
        if (mem_wr_o) begin
            check("wr_expected", 32'(wr_q.size() != 0), 1);
            check("wr_no_rd", mem_rd_o, 0);
            if (wr_q.size() != 0) begin
                mon_wr = wr_q.pop_front();
                check("wr_addr", mem_addr_o, mon_wr.addr);
                check("wr_data", mem_wdata_o, mon_wr.data);
            end
        end
        if (mem_rd_o) begin
            check("rd_expected", 32'(rd_q.size() != 0), 1);
            if (rd_q.size() != 0) begin
                mon_rd = rd_q.pop_front();
                check("rd_addr", mem_addr_o, mon_rd);
            end
        end
        if (cmd_err_o) err_count++;
        if (spi_miso_oe_o) oe_count++;
    end

    // Shift the top nbits of tx out on MOSI; MISO sampled as SCLK rises.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi_i = tx[i];
            repeat (HALF) @(negedge clk_i);
            rx[i] = spi_miso_o;
            spi_sclk_i = 1'b1;
            repeat (HALF) @(negedge clk_i);
            spi_sclk_i = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_cs_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("busy_before_3clk", busy_o, 0);
        @(negedge clk_i);
        check("busy_rise_3clk", busy_o, 1);
        repeat (HALF) @(negedge clk_i);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk_i);
        check("busy_in_frame", busy_o, 1);
        spi_cs_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("busy_hold_2clk", busy_o, 1);
        @(negedge clk_i);
        check("busy_fall_3clk", busy_o, 0);
        check("oe_after_cs", spi_miso_oe_o, 0);
        repeat (2 * HALF) @(negedge clk_i);
    endtask

    // Read nbytes; the target also prefetches the byte after the last one.
    task automatic read_frame(input logic [15:0] addr, input int nbytes);
        logic [7:0] rx;
        for (int k = 0; k <= nbytes; k++) rd_q.push_back(addr + 16'(k));
        cs_low();
        spi_xfer(8'h03, 8, rx);
        spi_xfer(addr[15:8], 8, rx);
        spi_xfer(addr[7:0], 8, rx);
        for (int k = 0; k < nbytes; k++) begin
            spi_xfer(8'h00, 8, rx);
            check("rd_oe", spi_miso_oe_o, 1);
            if (miso_q.size() != 0) check("miso_byte", rx, miso_q.pop_front());
            else check("miso_queue", 0, 1);
        end
        cs_high();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] rx;
        int         e0;
        int         o0;

        ram[16'h0020] = 8'h3C;
        ram[16'h0021] = 8'hC3;
        ram[16'h0022] = 8'h77;
        ram[16'h0005] = 8'h5A;
        ram[16'h0006] = 8'h66;
        rst_n_i    = 1'b1;
        spi_sclk_i = 1'b0;
        spi_cs_i   = 1'b1;
        spi_mosi_i = 1'b0;
        #2 rst_n_i = 1'b0;
        #1;
        check("rst_miso",   spi_miso_o, 0);
        check("rst_oe",     spi_miso_oe_o, 0);
        check("rst_addr",   mem_addr_o, 16'h0000);
        check("rst_rd",     mem_rd_o, 0);
        check("rst_wr",     mem_wr_o, 0);
        check("rst_wdata",  mem_wdata_o, 8'h00);
        check("rst_busy",   busy_o, 0);
        check("rst_cmderr", cmd_err_o, 0);
        repeat (4) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (4 * HALF) @(negedge clk_i);

        // Single-byte write
        wr_q.push_back('{addr: 16'h0010, data: 8'hA5});
        cs_low();
        spi_xfer(8'h02, 8, rx);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'h10, 8, rx);
        spi_xfer(8'hA5, 8, rx);
        cs_high();

        // Two-byte read
        miso_q.push_back(8'h3C);
        miso_q.push_back(8'hC3);
        read_frame(16'h0020, 2);

        // Address wrap on write, then read back across the wrap
        wr_q.push_back('{addr: 16'hFFFF, data: 8'h11});
        wr_q.push_back('{addr: 16'h0000, data: 8'h22});
        cs_low();
        spi_xfer(8'h02, 8, rx);
        spi_xfer(8'hFF, 8, rx);
        spi_xfer(8'hFF, 8, rx);
        spi_xfer(8'h11, 8, rx);
        spi_xfer(8'h22, 8, rx);
        cs_high();
        miso_q.push_back(8'h11);
        miso_q.push_back(8'h22);
        read_frame(16'hFFFF, 2);

        // Unrecognised command
        e0 = err_count;
        o0 = oe_count;
        cs_low();
        spi_xfer(8'h9F, 8, rx);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'h00, 8, rx);
        cs_high();
        check("bad_cmd_err_pulses", err_count - e0, 1);
        check("bad_cmd_oe_cycles", oe_count - o0, 0);

        // Abort mid-byte: no write, next read sees old contents
        cs_low();
        spi_xfer(8'h02, 8, rx);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'h05, 8, rx);
        spi_xfer(8'hF0, 4, rx);
        cs_high();
        miso_q.push_back(8'h5A);
        read_frame(16'h0005, 1);

        // Reset in the middle of a read data byte
        rd_q.push_back(16'h0020);
        cs_low();
        spi_xfer(8'h03, 8, rx);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'h20, 8, rx);
        spi_xfer(8'h00, 4, rx);
        check("mid_read_oe", spi_miso_oe_o, 1);
        rst_n_i = 1'b0;
        #1;
        check("async_rst_oe",   spi_miso_oe_o, 0);
        check("async_rst_miso", spi_miso_o, 0);
        check("async_rst_busy", busy_o, 0);
        check("async_rst_addr", mem_addr_o, 16'h0000);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        // CS still low: the rest of this frame must be ignored
        spi_xfer(8'h02, 8, rx);
        check("post_rst_busy", busy_o, 0);
        check("post_rst_oe", spi_miso_oe_o, 0);
        spi_cs_i = 1'b1;
        repeat (3 * HALF) @(negedge clk_i);
        check("post_rst_idle", busy_o, 0);
        miso_q.push_back(8'h3C);
        read_frame(16'h0020, 1);

        check("wr_q_drained", wr_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        check("total_cmd_err", err_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_mem_target.md
# spi_mem_target

SPI responder (slave) that terminates the external memory bus driven by the core's SPI master and maps it onto a simple synchronous single-port RAM interface. It sits on the far side of the SPI pins, on a board-level emulator or in a test harness, and lets an on-chip or FPGA RAM stand in for the external instruction/data SPI SRAM. It oversamples SCLK/CS/MOSI with its own clock, decodes READ/WRITE commands with a 16-bit address, and streams bytes with address auto-increment.

## Interface
- CMD_READ, 8'h03, command byte selecting read
- CMD_WRITE, 8'h02, command byte selecting write
- clk_i  in  1  target clock; must be ≥ 8× SCLK frequency
- rst_n_i  in  1  reset, asynchronous, active-low
- spi_sclk_i  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0)
- spi_cs_i  in  1  chip select, active-low
- spi_mosi_i  in  1  master-out data, MSB first
- spi_miso_o  out  1  target-out data, MSB first
- spi_miso_oe_o  out  1  MISO output enable; 1 only during read data phase
- mem_addr_o  out  16  RAM address
- mem_rd_o  out  1  one-cycle read strobe
- mem_rdata_i  in  8  RAM read data, valid exactly 1 clk_i after mem_rd_o
- mem_wr_o  out  1  one-cycle write strobe
- mem_wdata_o  out  8  RAM write data, valid with mem_wr_o
- busy_o  out  1  1 while a transaction is active (CS low, synchronized)
- cmd_err_o  out  1  one-cycle pulse on unrecognized command byte

## Operation
- spi_sclk_i, spi_cs_i, spi_mosi_i each pass a 2-flop synchronizer; edges of SCLK detected from synchronized value and its previous sample. All logic runs in clk_i only.
- Frame: CS falls; 8-bit command; 16-bit address (MSB first); then 1..N data bytes; CS rises.
- MOSI sampled on SCLK rising edge; MISO updated on SCLK falling edge.
- States: IDLE, CMD, ADDR, RD_FETCH, RD_DATA, WR_DATA, IGNORE.
- IDLE → CMD on synchronized CS falling; bit counter cleared.
- CMD: after 8th rising edge, CMD_READ or CMD_WRITE → ADDR; any other value → IGNORE with cmd_err_o pulse.
- ADDR: after 16th rising edge, latch address into mem_addr_o; READ → RD_FETCH, WRITE → WR_DATA.
- RD_FETCH: assert mem_rd_o one cycle; next cycle load mem_rdata_i into TX shift register, drive MSB onto spi_miso_o, raise spi_miso_oe_o, → RD_DATA.
- RD_DATA: shift on each falling edge; after 8th rising edge of a byte, increment address and issue next mem_rd_o; reload shift register before next falling edge.
- WR_DATA: shift MOSI into RX register; on 8th rising edge of each byte assert mem_wr_o with mem_addr_o/mem_wdata_o for one cycle, then increment address.
- Address increment is 16-bit modulo: 16'hFFFF → 16'h0000.
- IGNORE: MISO not driven; no memory strobes until CS rises.
- Synchronized CS rising in any state → IDLE immediately; partial byte discarded (no mem_wr_o); pending read data dropped; spi_miso_oe_o deasserted same cycle.
- mem_rd_o and mem_wr_o never asserted in the same cycle.

## Timing
- Reset values: spi_miso_o=0, spi_miso_oe_o=0, mem_addr_o=16'h0000, mem_rd_o=0, mem_wr_o=0, mem_wdata_o=8'h00, busy_o=0, cmd_err_o=0, state IDLE.
- Input latency: 2 clk_i synchronizer + 1 clk_i edge detect.
- mem_wr_o asserted 1 clk_i after detecting the 8th rising edge of a data byte.
- First read byte MSB on MISO ≤ 3 clk_i after detecting 24th rising edge; requires SCLK low/high phases ≥ 4 clk_i each (master CLOCK_DIVIDER=4 satisfies this).
- busy_o rises 3 clk_i after CS falls and falls 3 clk_i after CS rises.
- Async reset mid-frame: all outputs to reset values immediately; after release, target waits in IDLE for next CS falling (current frame ignored even if CS still low).

## Test plan
- Write 1 byte: CS low, 02 00 10 A5, CS high → single mem_wr_o with addr 16'h0010, wdata 8'hA5; no mem_rd_o.
- Read 2 bytes: RAM[0x0020]=3C, [0x0021]=C3; send 03 00 20 + 16 clocks → MISO returns 3C then C3; mem_rd_o at 0x0020 and 0x0021.
- Wrap: write 02 FF FF 11 22 → writes 0xFFFF=11, then 0x0000=22.
- Bad command 0x9F + 24 clocks → cmd_err_o one pulse, no mem strobes, spi_miso_oe_o stays 0, busy_o until CS high.
- Abort: 02 00 05 then 4 data bits, CS high → no mem_wr_o; next frame 03 00 05 behaves normally.
- Reset asserted mid-read → all outputs reset same cycle; next full frame succeeds.
